// File: rtl/joy_pkg.sv
// -----------------------------------------------------------------------------
// joy_pkg
// Shared definitions for the DB15 serial joystick path.
//   - DB15_BITS : bits per player carried in the 74x165 chain
//   - JB_*      : button bit positions inside a player vector
//   - joy_vec_t : one player's active-high button vector
// -----------------------------------------------------------------------------
package joy_pkg;

    localparam int DB15_BITS = 12;

    // Button bit positions (active-high in joy_vec_t)
    localparam int JB_R  = 0;
    localparam int JB_L  = 1;
    localparam int JB_D  = 2;
    localparam int JB_U  = 3;
    localparam int JB_B1 = 4;
    localparam int JB_B2 = 5;
    localparam int JB_B3 = 6;
    localparam int JB_B4 = 7;
    localparam int JB_B5 = 8;
    localparam int JB_B6 = 9;
    localparam int JB_B7 = 10;
    localparam int JB_B8 = 11;

    typedef logic [DB15_BITS-1:0] joy_vec_t;

endpackage

// File: rtl/joy_db15_tx_if.sv
// -----------------------------------------------------------------------------
// joy_db15_tx_if
// The three DB15 adapter wires between host (reader) and device (this block).
//   JOY_LOAD : host -> device, active-low parallel load strobe
//   JOY_CLK  : host -> device, shift clock
//   JOY_DATA : device -> host, serial data, active-low buttons
// Modports:
//   master : host side (drives LOAD/CLK, reads DATA)
//   slave  : device side (reads LOAD/CLK, drives DATA)
// -----------------------------------------------------------------------------
interface joy_db15_tx_if;

    logic JOY_LOAD;
    logic JOY_CLK;
    logic JOY_DATA;

    modport master (
        output JOY_LOAD,
        output JOY_CLK,
        input  JOY_DATA
    );

    modport slave (
        input  JOY_LOAD,
        input  JOY_CLK,
        output JOY_DATA
    );

endinterface

// File: rtl/joy_db15_tx_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchroniser for an asynchronous pin plus a third history flop used
// for edge detection.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   i_async   : asynchronous input pin
//   o_level   : synchronised level
//   o_rise    : one-clk pulse on a synchronised rising edge
//   o_fall    : one-clk pulse on a synchronised falling edge
// RST_VAL is the idle level of the pin; all three flops reset to it so no
// spurious edge is reported when reset releases with the pin idle.
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // r_sync[0], r_sync[1] form the synchroniser; r_sync[2] is edge history
    logic [2:0] r_sync;

    // Synchroniser and history shift chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {3{RST_VAL}};
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    assign o_level = r_sync[1];
    assign o_rise  =  r_sync[1] & ~r_sync[2];
    assign o_fall  = ~r_sync[1] &  r_sync[2];

endmodule

// File: rtl/joy_db15_tx.sv
// -----------------------------------------------------------------------------
// joy_db15_tx
// Device-side emulation of the DB15 adapter's 74x165 parallel-in/serial-out
// chain. Two player vectors are loaded while the host holds JOY_LOAD low and
// shifted out (player 1 bit0 first) on each JOY_CLK rising edge. Also reports
// frame completion and a load-pulse watchdog.
// Ports:
//   clk        : system clock (40-50 MHz)
//   RESET      : asynchronous active-high reset
//   joy1, joy2 : player button vectors, active-high
//   db15       : adapter wires (slave side: LOAD/CLK in, DATA out)
//   frame_done : one-clk pulse when the last bit of a frame is shifted
//   frame_cnt  : wrapping count of completed frames
//   link_ok    : high while load pulses keep arriving within TIMEOUT clk
// -----------------------------------------------------------------------------
module joy_db15_tx
    import joy_pkg::*;
#(
    parameter int          BITS    = DB15_BITS,
    parameter logic [23:0] TIMEOUT = 24'd4800000
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [BITS-1:0]   joy1,
    input  logic [BITS-1:0]   joy2,
    joy_db15_tx_if.slave      db15,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              link_ok
);

    localparam int FRAME_LEN = 2 * BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [23:0]      WD_ONE     = 24'd1;
    localparam logic [7:0]       FCNT_ONE   = 8'd1;

    // Synchronised pin views
    logic w_load_lvl;
    logic w_load_rise;
    logic w_load_fall;
    logic w_clk_lvl;
    logic w_clk_rise;
    logic w_clk_fall;
    logic w_unused_edges;

    // State
    logic [FRAME_LEN-1:0] r_shreg;
    logic [CNT_W-1:0]     r_bitcnt;
    logic                 r_data;
    logic                 r_frame_done;
    logic [7:0]           r_frame_cnt;
    logic [23:0]          r_wdog;
    logic                 r_link_ok;

    // Next-state
    logic [FRAME_LEN-1:0] w_shreg_nxt;
    logic [CNT_W-1:0]     w_bitcnt_nxt;
    logic                 w_done_nxt;
    logic [7:0]           w_frame_cnt_nxt;
    logic [23:0]          w_wdog_nxt;
    logic                 w_link_nxt;

    // LOAD idles high; reset to 1 so leaving reset is not seen as a load edge
    sync_edge #(.RST_VAL(1'b1)) u_sync_load (
        .clk     (clk),
        .rst     (RESET),
        .i_async (db15.JOY_LOAD),
        .o_level (w_load_lvl),
        .o_rise  (w_load_rise),
        .o_fall  (w_load_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
        .clk     (clk),
        .rst     (RESET),
        .i_async (db15.JOY_CLK),
        .o_level (w_clk_lvl),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    // Edges/levels not needed by the chain model
    assign w_unused_edges = w_load_rise | w_clk_fall | w_clk_lvl;

    // Chain next-state: transparent reload while LOAD is low (it also masks
    // CLK edges), otherwise shift in 1s with a saturating bit counter
    always_comb begin
        w_shreg_nxt     = r_shreg;
        w_bitcnt_nxt    = r_bitcnt;
        w_done_nxt      = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt;
        if (!w_load_lvl) begin
            w_shreg_nxt  = ~{joy2, joy1};
            w_bitcnt_nxt = CNT_ZERO;
        end else if (w_clk_rise) begin
            w_shreg_nxt = {1'b1, r_shreg[FRAME_LEN-1:1]};
            if (r_bitcnt != FRAME_END) begin
                w_bitcnt_nxt = r_bitcnt + CNT_ONE;
            end else begin
                w_bitcnt_nxt = r_bitcnt;
            end
            if (r_bitcnt == FRAME_LAST) begin
                w_done_nxt      = 1'b1;
                w_frame_cnt_nxt = r_frame_cnt + FCNT_ONE;
            end else begin
                w_done_nxt      = 1'b0;
            end
        end else begin
            w_shreg_nxt  = r_shreg;
            w_bitcnt_nxt = r_bitcnt;
        end
    end

    // Watchdog next-state: a LOAD fall restarts the count and raises link_ok;
    // link_ok drops on the cycle the count reaches TIMEOUT, then it saturates
    always_comb begin
        w_wdog_nxt = r_wdog;
        w_link_nxt = r_link_ok;
        if (w_load_fall) begin
            w_wdog_nxt = 24'd0;
            w_link_nxt = 1'b1;
        end else if (r_wdog != TIMEOUT) begin
            w_wdog_nxt = r_wdog + WD_ONE;
            if (w_wdog_nxt == TIMEOUT) begin
                w_link_nxt = 1'b0;
            end else begin
                w_link_nxt = r_link_ok;
            end
        end else begin
            w_link_nxt = 1'b0;
        end
    end

    // State registers; JOY_DATA is a registered copy of the chain's tail bit
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_shreg      <= {FRAME_LEN{1'b1}};
            r_bitcnt     <= CNT_ZERO;
            r_data       <= 1'b1;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_wdog       <= 24'd0;
            r_link_ok    <= 1'b0;
        end else begin
            r_shreg      <= w_shreg_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_data       <= r_shreg[0];
            r_frame_done <= w_done_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_wdog       <= w_wdog_nxt;
            r_link_ok    <= w_link_nxt;
        end
    end

    assign db15.JOY_DATA = r_data;
    assign frame_done    = r_frame_done;
    assign frame_cnt     = r_frame_cnt;
    assign link_ok       = r_link_ok;

endmodule

// File: tb/tb_joy_db15_tx.sv
// -----------------------------------------------------------------------------
// tb_joy_db15_tx
// Directed bench for joy_db15_tx acting as a DB15 host. Expected serial bits
// are queued when a frame is loaded and popped as each bit is read.
// -----------------------------------------------------------------------------
module tb_joy_db15_tx;
    import joy_pkg::*;

    localparam int          BITS = DB15_BITS;
    localparam logic [23:0] TMO  = 24'd1000;

    logic       clk;
    logic       RESET;
    joy_vec_t   joy1;
    joy_vec_t   joy2;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic       link_ok;

    joy_db15_tx_if db15 ();

    joy_db15_tx #(.BITS(BITS), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .joy1       (joy1),
        .joy2       (joy2),
        .db15       (db15),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .link_ok    (link_ok)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_seen = 0;
    logic exp_q[$];

    // Count of posedges so far
    always @(posedge clk) cyc <= cyc + 1;

    // Count frame_done pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_seen <= done_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected serial stream after a load: ~joy1 LSB first, ~joy2, then 1s
    task automatic push_frame(input joy_vec_t j1, input joy_vec_t j2, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < BITS)          exp_q.push_back(~j1[i]);
            else if (i < 2 * BITS) exp_q.push_back(~j2[i - BITS]);
            else                   exp_q.push_back(1'b1);
        end
    endtask

    task automatic load_pulse(input int hold);
        db15.JOY_LOAD = 1'b0;
        tick(hold);
        db15.JOY_LOAD = 1'b1;
    endtask

    // Read n bits: each bit is sampled at the end of the CLK-low period
    task automatic shifts(input int n, input int hold, input bit chk, input string tag);
        logic e;
        for (int i = 0; i < n; i++) begin
            tick(hold);
            if (chk) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                check($sformatf("%s_bit%0d", tag, i), {31'd0, db15.JOY_DATA}, {31'd0, e});
            end
            db15.JOY_CLK = 1'b1;
            tick(hold);
            db15.JOY_CLK = 1'b0;
        end
    endtask

    initial begin
        int d0;
        int fall_cyc;
        RESET         = 1'b1;
        joy1          = 12'h000;
        joy2          = 12'h000;
        db15.JOY_LOAD = 1'b1;
        db15.JOY_CLK  = 1'b0;

        // Reset state, held for 5 clk
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("rst_data%0d", i), {31'd0, db15.JOY_DATA}, 32'd1);
            check($sformatf("rst_link%0d", i), {31'd0, link_ok}, 32'd0);
            check($sformatf("rst_fcnt%0d", i), {24'd0, frame_cnt}, 32'd0);
            check($sformatf("rst_done%0d", i), {31'd0, frame_done}, 32'd0);
        end
        RESET = 1'b0;
        tick(10);
        check("idle_data", {31'd0, db15.JOY_DATA}, 32'd1);
        check("idle_link", {31'd0, link_ok}, 32'd0);
        check("idle_fcnt", {24'd0, frame_cnt}, 32'd0);

        // Frame 1: only P1 R and P2 bit11 pressed
        joy1 = 12'h001;
        joy2 = 12'h800;
        d0 = done_seen;
        load_pulse(8);
        check("f1_link", {31'd0, link_ok}, 32'd1);
        push_frame(joy1, joy2, 24);
        shifts(23, 8, 1'b1, "f1");
        tick(8);
        check("f1_nodone23", done_seen - d0, 32'd0);
        shifts(1, 8, 1'b1, "f1_last");
        tick(8);
        check("f1_done", done_seen - d0, 32'd1);
        check("f1_fcnt", {24'd0, frame_cnt}, 32'd1);

        // LOAD low overrides CLK; inputs change during the load
        joy1 = 12'h000;
        joy2 = 12'h000;
        d0 = done_seen;
        db15.JOY_LOAD = 1'b0;
        tick(6);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) joy1 = 12'h010;
            db15.JOY_CLK = 1'b1;
            tick(4);
            db15.JOY_CLK = 1'b0;
            tick(4);
        end
        tick(4);
        db15.JOY_LOAD = 1'b1;
        check("ld_nodone", done_seen - d0, 32'd0);
        push_frame(12'h010, 12'h000, 24);
        shifts(23, 8, 1'b1, "ld");
        tick(8);
        check("ld_nodone23", done_seen - d0, 32'd0);
        shifts(1, 8, 1'b1, "ld_last");
        tick(8);
        check("ld_done", done_seen - d0, 32'd1);
        check("ld_fcnt", {24'd0, frame_cnt}, 32'd2);

        // Aborted frame followed by a full one
        joy1 = 12'hA5C;
        joy2 = 12'h3C1;
        d0 = done_seen;
        load_pulse(8);
        push_frame(joy1, joy2, 10);
        shifts(10, 8, 1'b1, "ab_part");
        joy1 = 12'h5A3;
        load_pulse(8);
        push_frame(joy1, joy2, 24);
        shifts(24, 8, 1'b1, "ab_full");
        tick(8);
        check("ab_done", done_seen - d0, 32'd1);
        check("ab_fcnt", {24'd0, frame_cnt}, 32'd3);

        // Over-shift: trailing bits are 1, still a single pulse
        joy1 = 12'h0F0;
        joy2 = 12'hF0F;
        d0 = done_seen;
        load_pulse(8);
        push_frame(joy1, joy2, 26);
        shifts(26, 8, 1'b1, "ov");
        tick(8);
        check("ov_done", done_seen - d0, 32'd1);
        check("ov_fcnt", {24'd0, frame_cnt}, 32'd4);
        check("ov_qempty", exp_q.size(), 32'd0);

        // Watchdog: let the link lapse, then three loads and an exact timeout
        tick(int'(TMO) + 10);
        check("wd_lapsed", {31'd0, link_ok}, 32'd0);
        fall_cyc = 0;
        for (int p = 0; p < 3; p++) begin
            tick(400);
            fall_cyc = cyc;
            load_pulse(6);
            check($sformatf("wd_up%0d", p), {31'd0, link_ok}, 32'd1);
        end
        // Synced fall clears the watchdog 3 edges after the pin is driven
        while (cyc < fall_cyc + 3 + int'(TMO) - 1) tick(1);
        check("wd_before", {31'd0, link_ok}, 32'd1);
        tick(1);
        check("wd_drop", {31'd0, link_ok}, 32'd0);

        // Reset mid-frame
        load_pulse(8);
        shifts(5, 8, 1'b0, "rm");
        RESET = 1'b1;
        tick(1);
        check("rm_data", {31'd0, db15.JOY_DATA}, 32'd1);
        check("rm_fcnt", {24'd0, frame_cnt}, 32'd0);
        check("rm_link", {31'd0, link_ok}, 32'd0);
        tick(2);
        RESET = 1'b0;
        tick(4);

        // 256 frames: count passes 255 and wraps to 0
        d0 = done_seen;
        for (int f = 0; f < 256; f++) begin
            load_pulse(4);
            shifts(24, 4, 1'b0, "wr");
            tick(4);
            if (f == 254) check("wr_255", {24'd0, frame_cnt}, 32'd255);
        end
        check("wr_zero", {24'd0, frame_cnt}, 32'd0);
        check("wr_pulses", done_seen - d0, 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
